// File: rtl/spike_scheduler.sv
// Round-robin spike scheduler: latches per-synapse spikes and issues them one at a time
// with their weights over a valid/ready port. Optional counter: define SPIKE_SCHED_COUNT_EN.
module spike_scheduler #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          spike,
    input  logic [N*W-1:0]        weight,
    input  logic                  clear,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [$clog2(N)-1:0]  out_idx,
    output logic [W-1:0]          out_weight,
    output logic [N-1:0]          pending,
    output logic [N-1:0]          overflow,
    output logic [15:0]           grant_count
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t         state;
    state_t         state_next;
    logic           load;
    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_next;
    logic [N-1:0]   load_mask;
    logic [N-1:0]   pending_next;
    logic [N-1:0]   ovf_set;
    int             cand;

    assign out_valid = (state == HOLD);

    // Round-robin search: first pending bit at or after ptr, wrapping to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = {IW{1'b0}};
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end else begin
                sel_found = sel_found;
            end
        end
    end

    // FSM next state and load decision.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (out_ready && (|pending)) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end else if (out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending/overflow next values; a spike coinciding with its own issue re-arms the bit.
    always_comb begin
        load_mask    = {N{1'b0}};
        if (load) begin
            load_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;
        end else begin
            load_mask = {N{1'b0}};
        end
        pending_next = (pending & ~load_mask) | spike;
        ovf_set      = spike & pending & ~load_mask;
        ptr_next     = (sel_idx == IW'(N-1)) ? {IW{1'b0}} : sel_idx + IW'(1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output registers, pointer, pending and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx    <= {IW{1'b0}};
            out_weight <= {W{1'b0}};
            ptr        <= {IW{1'b0}};
            pending    <= {N{1'b0}};
            overflow   <= {N{1'b0}};
        end else begin
            if (load) begin
                out_idx    <= sel_idx;
                out_weight <= weight[int'(sel_idx)*W +: W];
                ptr        <= ptr_next;
            end
            if (clear) begin
                pending  <= {N{1'b0}};
                overflow <= {N{1'b0}};
            end else begin
                pending  <= pending_next;
                overflow <= overflow | ovf_set;
            end
        end
    end

`ifdef SPIKE_SCHED_COUNT_EN
    logic [15:0] count;

    // Saturating count of accepted events.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'h0000;
        end else if (out_valid && out_ready && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end else begin
            count <= count;
        end
    end

    assign grant_count = count;
`else
    assign grant_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed self-checking bench for spike_scheduler (N=8, W=8).
module tb_spike_scheduler;
    localparam int N = 8;
    localparam int W = 8;

`ifdef SPIKE_SCHED_COUNT_EN
    localparam logic [15:0] CNT_ONE   = 16'd1;
    localparam logic [15:0] CNT_EIGHT = 16'd8;
`else
    localparam logic [15:0] CNT_ONE   = 16'd0;
    localparam logic [15:0] CNT_EIGHT = 16'd0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   spike;
    logic [N*W-1:0] weight;
    logic           clear;
    logic           out_ready;
    logic           out_valid;
    logic [2:0]     out_idx;
    logic [W-1:0]   out_weight;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;
    logic [15:0]    grant_count;

    int n_checks = 0;
    int n_pass   = 0;

    spike_scheduler #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .spike(spike), .weight(weight), .clear(clear),
        .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
        .out_weight(out_weight), .pending(pending), .overflow(overflow),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; spike = '0; clear = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) weight[i*W +: W] = 8'h10 + 8'(i);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_weight", 32'(out_weight), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(grant_count), 32'd0);

        // Single spike latency
        spike = 8'h01;
        tick();
        spike = 8'h00;
        check("lat_pending", 32'(pending), 32'h01);
        check("lat_valid_e", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_idx", 32'(out_idx), 32'd0);
        check("lat_weight", 32'(out_weight), 32'h10);
        tick();
        check("lat_done", 32'(out_valid), 32'd0);
        check("lat_count", 32'(grant_count), 32'(CNT_ONE));

        // Burst of all eight, back to back
        do_reset();
        spike = 8'hFF;
        tick();
        spike = 8'h00;
        for (int k = 0; k < N; k++) begin
            tick();
            check("burst_valid", 32'(out_valid), 32'd1);
            check("burst_idx", 32'(out_idx), 32'(k));
            check("burst_weight", 32'(out_weight), 32'(8'h10 + 8'(k)));
        end
        tick();
        check("burst_done", 32'(out_valid), 32'd0);
        check("burst_count", 32'(grant_count), 32'(CNT_EIGHT));

        // Stall with weight change
        do_reset();
        out_ready = 1'b0;
        spike = 8'h08;
        tick();
        spike = 8'h00;
        tick();
        check("stall_idx", 32'(out_idx), 32'd3);
        weight[3*W +: W] = 8'hAA;
        tick();
        tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_idx2", 32'(out_idx), 32'd3);
        check("stall_weight", 32'(out_weight), 32'h13);
        out_ready = 1'b1;
        tick();
        check("stall_release", 32'(out_valid), 32'd0);
        weight[3*W +: W] = 8'h13;

        // Overflow and clear
        do_reset();
        out_ready = 1'b0;
        spike = 8'h01;
        tick();
        spike = 8'h00;
        tick();
        spike = 8'h20;
        tick();
        tick();
        spike = 8'h00;
        check("ovf_flag", 32'(overflow), 32'h20);
        check("ovf_pending", 32'(pending), 32'h20);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pending", 32'(pending), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd1);
        check("clr_idx", 32'(out_idx), 32'd0);

        // Spike coinciding with its own issue
        do_reset();
        out_ready = 1'b1;
        spike = 8'h34;
        tick();
        spike = 8'h04;
        tick();
        spike = 8'h00;
        check("coin_idx", 32'(out_idx), 32'd2);
        check("coin_pending", 32'(pending), 32'h34);
        check("coin_overflow", 32'(overflow), 32'd0);
        tick();
        check("coin_idx4", 32'(out_idx), 32'd4);
        tick();
        check("coin_idx5", 32'(out_idx), 32'd5);
        tick();
        check("coin_reissue", 32'(out_idx), 32'd2);
        check("coin_valid", 32'(out_valid), 32'd1);
        tick();
        check("coin_done", 32'(out_valid), 32'd0);

        // Reset mid-HOLD
        do_reset();
        out_ready = 1'b0;
        spike = 8'h0D;
        tick();
        spike = 8'h00;
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pending", 32'(pending), 32'h0C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_idx", 32'(out_idx), 32'd0);
        check("mid_weight", 32'(out_weight), 32'd0);
        check("mid_pending", 32'(pending), 32'd0);
        check("mid_count", 32'(grant_count), 32'd0);
        out_ready = 1'b1;
        spike = 8'h10;
        tick();
        spike = 8'h00;
        tick();
        check("post_idx", 32'(out_idx), 32'd4);
        check("post_weight", 32'(out_weight), 32'h14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spike_scheduler.md
SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of synapse requesters (2..32).
REQ-002 SHALL have parameter W, default 8, meaning synaptic weight width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spike  input  N  per-synapse spike pulses, one bit per requester.
REQ-006 SHALL have port weight  input  N*W  flattened per-synapse weights; slice i is bits [i*W +: W].
REQ-007 SHALL have port clear  input  1  synchronous clear of pending and overflow state.
REQ-008 SHALL have port out_ready  input  1  downstream neuron integrator accepts the current event.
REQ-009 SHALL have port out_valid  output  1  an event is presented.
REQ-010 SHALL have port out_idx  output  clog2(N)  index of the presented synapse.
REQ-011 SHALL have port out_weight  output  W  weight of the presented synapse.
REQ-012 SHALL have port pending  output  N  latched spikes not yet issued.
REQ-013 SHALL have port overflow  output  N  sticky per-synapse dropped-spike flags.
REQ-014 SHALL have port grant_count  output  16  accepted-event counter (see Configuration).

Function
REQ-015 SHALL set pending[i] at the clock edge where spike[i]=1 is sampled.
REQ-016 SHALL use a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-017 SHALL load the output register when state is IDLE or (HOLD and out_ready=1), and pending is non-zero.
REQ-018 SHALL select on load the first set pending bit at or after round-robin pointer ptr, wrapping from N-1 to 0.
REQ-019 SHALL on load: set out_idx to the selected index, capture weight slice out_idx into out_weight, clear that pending bit, set ptr to (index+1) mod N, go to or stay in HOLD.
REQ-020 SHALL go to IDLE when in HOLD with out_ready=1 and pending is zero.
REQ-021 SHALL hold out_idx and out_weight stable while out_valid=1 and out_ready=0.
REQ-022 SHALL give a latency of one cycle: spike sampled at edge E with FSM IDLE and no other pending bits gives out_valid=1 after edge E+1.
REQ-023 SHALL sustain one accepted event per cycle while out_ready=1 and requests remain.
REQ-024 SHALL let a spike on bit i win when it coincides with the load that clears pending[i]: pending[i] remains 1 and no overflow is flagged.
REQ-025 SHALL flag a spike on bit i while pending[i]=1 and not being cleared that cycle: the spike is dropped and overflow[i] set to 1, staying set until clear or reset.
REQ-026 SHALL make clear=1 zero pending and overflow, ignoring spikes in that cycle; it does not alter out_valid, the output registers, ptr, or grant_count.
REQ-027 SHALL leave a weight change after capture with no effect on the presented event.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set state IDLE, out_valid 0, out_idx 0, out_weight 0, pending 0, overflow 0, ptr 0 and grant_count 0.
REQ-029 SHALL, on reset mid-HOLD, discard the presented event without requiring handshake completion.
REQ-030 SHALL make reset take priority over clear, spike and out_ready.

Configuration
REQ-031 SHALL use macro SPIKE_SCHED_COUNT_EN. When defined, grant_count increments by 1 on each cycle with out_valid=1 and out_ready=1, saturating at 65535. When undefined, grant_count is tied to 0 and no counter flops are built.

Verification
REQ-032 SHALL cover: N=8; spike=0x01 at edge E, out_ready=1 -> out_valid=1, out_idx=0, out_weight=weight[7:0] after E+1; out_valid=0 after E+2.
REQ-033 SHALL cover: spike=0xFF for one cycle, out_ready=1 -> idx 0,1,...,7 on 8 consecutive cycles, then out_valid=0; grant_count=8 with the macro, 0 without.
REQ-034 SHALL cover: out_ready=0 with idx 3 presented, weight slice 3 changed -> out_idx=3 and out_weight unchanged until out_ready=1.
REQ-035 SHALL cover: pending[5]=1, second spike[5] before issue -> overflow=0x20; after clear=1, pending=0 and overflow=0.
REQ-036 SHALL cover: spike[2] in the same cycle that idx 2 is loaded -> pending[2]=1 after that edge, overflow[2]=0, and idx 2 reissued after the other pending bits.
REQ-037 SHALL cover: reset=1 while in HOLD with pending=0x0C -> all outputs 0 the next cycle; a following spike=0x10 issues idx 4 first (ptr=0).
